// File: rtl/fifo_rd_drain.sv
// Read-side FIFO drain: pops words with zero-latency capture and presents them
// on a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_INC,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [CNT_WIDTH-1:0]  POP_CNT
);

  typedef enum logic [1:0] {
    BUF0 = 2'd0,
    BUF1 = 2'd1,
    BUF2 = 2'd2
  } occ_e;

  occ_e                  state, state_nxt;
  logic [DATA_WIDTH-1:0] e0, e0_nxt;
  logic [DATA_WIDTH-1:0] e1, e1_nxt;
  logic [CNT_WIDTH-1:0]  pop_cnt;
  logic                  push;
  logic                  cons;

  // Pop depends only on registered occupancy, never on OUT_READY.
  assign push      = !RST && EN && !EMPTY && (state != BUF2);
  assign RD_INC    = push;
  assign OUT_VALID = (state != BUF0);
  assign OUT_DATA  = e0;
  assign POP_CNT   = pop_cnt;
  assign cons      = OUT_VALID && OUT_READY;

  always_comb begin
    state_nxt = state;
    e0_nxt    = e0;
    e1_nxt    = e1;
    unique case (state)
      BUF0: begin
        if (push) begin
          state_nxt = BUF1;
          e0_nxt    = RD_DATA;
        end
      end
      BUF1: begin
        if (push && !cons) begin
          state_nxt = BUF2;
          e1_nxt    = RD_DATA;
        end else if (push && cons) begin
          e0_nxt    = RD_DATA;
        end else if (cons) begin
          state_nxt = BUF0;
        end
      end
      BUF2: begin
        if (cons) begin
          state_nxt = BUF1;
          e0_nxt    = e1;
        end
      end
      default: begin
        state_nxt = BUF0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= BUF0;
      e0      <= '0;
      e1      <= '0;
      pop_cnt <= '0;
    end else begin
      state <= state_nxt;
      e0    <= e0_nxt;
      e1    <= e1_nxt;
      if (push) begin
        pop_cnt <= pop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Scoreboard bench for fifo_rd_drain: a queue-based FIFO and buffer model
// drives stimulus; a monitor checks every delivered word in order.
module tb_fifo_rd_drain;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN = 1'b1;
  logic          EMPTY = 1'b0;
  logic [DW-1:0] RD_DATA = '0;
  logic          RD_INC;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [CW-1:0] POP_CNT;

  fifo_rd_drain #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .EMPTY    (EMPTY),
    .RD_DATA  (RD_DATA),
    .RD_INC   (RD_INC),
    .OUT_DATA (OUT_DATA),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .POP_CNT  (POP_CNT)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            model_cnt = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic          rst_d = 1'b1;
  logic          en_d = 1'b1;
  int            rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic do_cycle();
    logic exp_inc;
    @(negedge CLK);
    cyc++;
    RST = rst_d;
    EN  = en_d;
    case (rdy_mode)
      0:       OUT_READY = 1'b0;
      1:       OUT_READY = 1'b1;
      2:       OUT_READY = cyc[0];
      default: OUT_READY = 1'($urandom_range(0, 1));
    endcase
    EMPTY   = (fifo_q.size() == 0);
    RD_DATA = EMPTY ? DW'($urandom) : fifo_q[0];
    #1;
    exp_inc = !rst_d && en_d && (fifo_q.size() > 0) && (exp_q.size() < 2);
    chk("rd_inc", 32'(RD_INC), 32'(exp_inc));
    chk("pop_cnt", 32'(POP_CNT), 32'(model_cnt % (1 << CW)));
    @(posedge CLK);
    if (rst_d) begin
      exp_q.delete();
      model_cnt = 0;
    end else if (exp_inc) begin
      exp_q.push_back(fifo_q.pop_front());
      model_cnt++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(DW'(base + i));
  endtask

  task automatic drain();
    int k;
    k = 0;
    rdy_mode = 1;
    en_d     = 1'b1;
    while ((fifo_q.size() > 0 || exp_q.size() > 0) && k < 60) begin
      do_cycle();
      k++;
    end
    do_cycle();
    chk("drained_valid", 32'(OUT_VALID), 32'd0);
  endtask

  // Monitor: in-order delivery against the scoreboard.
  always @(negedge CLK) begin
    #2;
    chk("out_valid", 32'(OUT_VALID), 32'(exp_q.size() != 0));
    if (OUT_VALID && exp_q.size() > 0) begin
      chk("out_data", 32'(OUT_DATA), 32'(exp_q[0]));
      if (OUT_READY && !RST) void'(exp_q.pop_front());
    end
  end

  initial begin
    load(8'h11, 8);
    rst_d = 1'b1;
    en_d  = 1'b1;
    run(2);
    chk("reset_out_data", 32'(OUT_DATA), 32'd0);

    rst_d    = 1'b0;
    rdy_mode = 1;
    run(12);
    chk("stream_cnt", 32'(POP_CNT), 32'd8);

    load(8'hA0, 5);
    rdy_mode = 0;
    run(6);
    chk("bp_hold", 32'(OUT_DATA), 32'hA0);
    rdy_mode = 1;
    run(8);

    load(8'hA0, 5);
    rdy_mode = 0;
    run(3);
    en_d     = 1'b0;
    rdy_mode = 1;
    run(4);
    en_d = 1'b1;
    run(6);

    load(8'h00, 10);
    rdy_mode = 2;
    run(25);
    drain();

    rdy_mode = 3;
    for (int i = 0; i < 300; i++) begin
      en_d = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0) fifo_q.push_back(DW'($urandom));
      do_cycle();
    end
    drain();

    load(8'h50, 5);
    rdy_mode = 0;
    run(3);
    rst_d = 1'b1;
    run(2);
    chk("mid_rst_data", 32'(OUT_DATA), 32'd0);
    rst_d = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
Read-side drain stage that sits directly downstream of the async FIFO memory/read-pointer logic, in the read clock domain. It watches the FIFO EMPTY flag and samples the combinational RD_DATA word. It issues one-cycle RD_INC pops and presents the words on a valid/ready stream through a 2-entry skid buffer. Consumers such as the UART TX byte loader get full-throughput, in-order delivery without a combinational path from OUT_READY to RD_INC.

Parameters:
DATA_WIDTH, 8, width of FIFO data word and output stream word
CNT_WIDTH, 16, width of the pop counter

Ports:
CLK  input  1  read-domain clock
RST  input  1  synchronous, active-high reset
EN  input  1  drain enable; 0 = no new pops, buffered words still delivered
EMPTY  input  1  FIFO empty flag (read-domain, registered upstream)
RD_DATA  input  DATA_WIDTH  FIFO word at current read address (combinational from FIFO memory)
RD_INC  output  1  pop strobe to FIFO read pointer, one cycle per word
OUT_DATA  output  DATA_WIDTH  head word of skid buffer
OUT_VALID  output  1  head word valid
OUT_READY  input  1  consumer accepts head word this cycle
POP_CNT  output  CNT_WIDTH  total words popped since reset, wraps

Behaviour:
- Clocking: single clock CLK. Reset: RST synchronous, active-high, sampled on posedge CLK.
- Reset values: occupancy = 0, both entries = 0, OUT_VALID = 0, OUT_DATA = 0, POP_CNT = 0. RD_INC = 0 in every cycle RST is high.
- State: registered occupancy with 3 states: BUF0 (0 words), BUF1 (1 word), BUF2 (2 words). Entries are E0 (head) and E1.
- Pop rule, combinational from registered state: RD_INC = !RST && EN && !EMPTY && (state != BUF2). RD_INC must not depend on OUT_READY.
- Push: when RD_INC = 1, RD_DATA is captured into the buffer on the same posedge. Zero-cycle pop latency.
- Consume: cons = OUT_VALID && OUT_READY.
- OUT_VALID = (state != BUF0). OUT_DATA = E0. Both are driven from registers only.
- Transitions (push, cons):
  - BUF0: push -> BUF1, E0 <= RD_DATA. No push -> stay.
  - BUF1: push & !cons -> BUF2, E1 <= RD_DATA. Push & cons -> BUF1, E0 <= RD_DATA. !push & cons -> BUF0. Neither -> stay.
  - BUF2: push is impossible. Cons -> BUF1, E0 <= E1. No cons -> stay.
- Throughput: with EN = 1, a non-empty FIFO and OUT_READY held at 1, there is one word per cycle. Steady state is BUF1. First-word latency is 1 cycle from the pop to OUT_VALID.
- Ordering: words leave in exactly the order popped. No drop, no duplication.
- POP_CNT increments by 1 on every RD_INC cycle. It wraps from 2^CNT_WIDTH-1 to 0.
- EN deasserted mid-stream: RD_INC goes to 0 in that same cycle. Buffered words keep draining under OUT_READY.
- EMPTY asserted while buffer not full: no pop. Buffer contents are unaffected.
- OUT_READY held low: at most 2 words are pulled from the FIFO, then RD_INC stays 0 until a consume.
- Holding rule: OUT_DATA and OUT_VALID must stay stable while OUT_VALID = 1 and OUT_READY = 0.
- Reset mid-operation: buffered words are discarded and POP_CNT clears. FIFO pointers belong to the FIFO and are not touched by this block.

Test Plan:
- Reset: RST = 1 for 2 cycles with EN = 1, EMPTY = 0 -> RD_INC = 0, OUT_VALID = 0, OUT_DATA = 0x00, POP_CNT = 0 throughout.
- Streaming: FIFO preloaded with 0x11..0x18, EN = 1, OUT_READY = 1 -> RD_INC high 8 consecutive cycles. OUT_DATA = 0x11..0x18 on 8 consecutive cycles, starting 1 cycle after the first RD_INC. POP_CNT = 8. Then EMPTY = 1 and OUT_VALID = 0.
- Backpressure: 5 words 0xA0..0xA4, OUT_READY = 0 -> exactly 2 pops, OUT_DATA held at 0xA0, RD_INC = 0 thereafter. Release OUT_READY -> 0xA0..0xA4 delivered in order, POP_CNT = 5.
- Enable gating: EN dropped while state = BUF2 and 3 words remain in FIFO -> no RD_INC. 0xA0 and 0xA1 still drain. Re-raise EN -> remaining 3 words delivered in order.
- Alternating OUT_READY 1/0 over 10 words 0x00..0x09 -> no loss or duplication; OUT_DATA stable whenever OUT_VALID && !OUT_READY.
- Counter wrap and mid-run reset: CNT_WIDTH = 4, pop 17 words -> POP_CNT = 1. Assert RST with state = BUF2 -> next cycle OUT_VALID = 0, POP_CNT = 0, RD_INC = 0 while RST is high.
